// File: rtl/ps2_key_decoder.sv
// ============================================================================
//  Module   : ps2_key_decoder
//  Brief    : PS/2 keyboard receiver producing a toggle-flagged key event word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 56000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int             c_WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT - 1);
    localparam logic [7:0]     c_FLT_MAX = 8'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {ps2_data, ps2_clk};

    // Line [0] is the PS/2 clock, line [1] the PS/2 data.
    for (genvar i = 0; i < 2; i++) begin : g_filter
        logic       r_s1;
        logic       r_s2;
        logic       r_filt;
        logic [7:0] r_cnt;

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_s1   <= 1'b1;
                r_s2   <= 1'b1;
                r_filt <= 1'b1;
                r_cnt  <= 8'd0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_filt) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == c_FLT_MAX) begin
                    r_filt <= r_s2;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end

        assign w_filt[i] = r_filt;
    end

    logic w_clk_f;
    logic w_data_f;
    logic r_clk_f_d;
    logic w_fall;

    assign w_clk_f  = w_filt[0];
    assign w_data_f = w_filt[1];
    assign w_fall   = r_clk_f_d & ~w_clk_f;

    state_t              r_state;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [c_WD_W-1:0]   r_wdog;
    logic                r_ext;
    logic                r_rel;
    logic [2:0]          r_skip;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_f_d <= 1'b1;
            r_state   <= S_IDLE;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_wdog    <= '0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_skip    <= 3'd0;
            ps2_key   <= 11'd0;
            frame_err <= 1'b0;
        end else begin
            r_clk_f_d <= w_clk_f;
            frame_err <= 1'b0;
            if (w_fall) begin
                r_wdog <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!w_data_f) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {w_data_f, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= w_data_f;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_data_f && (^{r_shift, r_parity})) begin
                            // Pause sequence swallowing overrides every other rule.
                            if (r_skip != 3'd0) begin
                                r_skip <= r_skip - 3'd1;
                            end else begin
                                case (r_shift)
                                    8'hE0: r_ext  <= 1'b1;
                                    8'hF0: r_rel  <= 1'b1;
                                    8'hE1: r_skip <= 3'd7;
                                    8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                                        r_ext <= 1'b0;
                                        r_rel <= 1'b0;
                                    end
                                    default: begin
                                        ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_shift};
                                        r_ext   <= 1'b0;
                                        r_rel   <= 1'b0;
                                    end
                                endcase
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (r_state == S_IDLE) begin
                r_wdog <= '0;
            end else if (r_wdog == c_WD_MAX) begin
                r_wdog    <= '0;
                r_state   <= S_IDLE;
                frame_err <= 1'b1;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Brief    : Directed self-checking bench for ps2_key_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    localparam int c_FILTER  = 8;
    localparam int c_TIMEOUT = 2000;

    logic        clk_sys;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int tog_cnt = 0;
    logic prev_b10 = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN (c_FILTER),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Counts frame_err pulse cycles and bit-10 toggles.
    always @(negedge clk_sys) begin
        if (frame_err === 1'b1)
            err_cnt++;
        if (ps2_key[10] !== prev_b10)
            tog_cnt++;
        prev_b10 = ps2_key[10];
    end

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (6) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk_sys);
            ps2_clk = 1'b1;
            repeat (11) @(negedge clk_sys);
        end else begin
            repeat (20) @(negedge clk_sys);
        end
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic p;
        p = bad_par ? (^b) : ~(^b);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++)
            ps2_bit(b[i], glitch);
        ps2_bit(p, glitch);
        ps2_bit(1'b1, glitch);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk_sys);
    endtask

    task automatic test_reset;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        n_tests++;
        if (ps2_key !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000);
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_make_break;
        int e0, t0;
        e0 = err_cnt;
        t0 = tog_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h61C) begin
            n_fail++;
            $display("FAIL make_a: got %h expected %h", ps2_key, 11'h61C);
        end
        send_frame(8'hF0, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h61C) begin
            n_fail++;
            $display("FAIL f0_prefix_hold: got %h expected %h", ps2_key, 11'h61C);
        end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h01C) begin
            n_fail++;
            $display("FAIL break_a: got %h expected %h", ps2_key, 11'h01C);
        end
        n_tests++;
        if (tog_cnt - t0 !== 2) begin
            n_fail++;
            $display("FAIL make_break_toggles: got %0d expected 2", tog_cnt - t0);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL make_break_errs: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_extended;
        send_frame(8'hE0, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h01C) begin
            n_fail++;
            $display("FAIL e0_hold: got %h expected %h", ps2_key, 11'h01C);
        end
        send_frame(8'h74, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h774) begin
            n_fail++;
            $display("FAIL ext_make: got %h expected %h", ps2_key, 11'h774);
        end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h774) begin
            n_fail++;
            $display("FAIL e0f0_hold: got %h expected %h", ps2_key, 11'h774);
        end
        send_frame(8'h74, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h174) begin
            n_fail++;
            $display("FAIL ext_break: got %h expected %h", ps2_key, 11'h174);
        end
    endtask

    task automatic test_bad_parity;
        int e0;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        n_tests++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL parity_err_pulse: got %0d expected 1", err_cnt - e0);
        end
        n_tests++;
        if (ps2_key !== 11'h174) begin
            n_fail++;
            $display("FAIL parity_key_hold: got %h expected %h", ps2_key, 11'h174);
        end
        send_frame(8'h5A, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h65A) begin
            n_fail++;
            $display("FAIL parity_recover: got %h expected %h", ps2_key, 11'h65A);
        end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (c_TIMEOUT + 100) @(negedge clk_sys);
        n_tests++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0);
        end
        send_frame(8'h16, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h216) begin
            n_fail++;
            $display("FAIL timeout_recover: got %h expected %h", ps2_key, 11'h216);
        end
    endtask

    task automatic test_pause_noise;
        int e0, t0;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        e0 = err_cnt;
        t0 = tog_cnt;
        for (int i = 0; i < 8; i++)
            send_frame(seq[i], 1'b0, 1'b1);
        n_tests++;
        if (ps2_key !== 11'h216) begin
            n_fail++;
            $display("FAIL pause_swallow: got %h expected %h", ps2_key, 11'h216);
        end
        send_frame(8'h05, 1'b0, 1'b1);
        n_tests++;
        if (ps2_key !== 11'h605) begin
            n_fail++;
            $display("FAIL pause_f1: got %h expected %h", ps2_key, 11'h605);
        end
        n_tests++;
        if (tog_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL pause_toggles: got %0d expected 1", tog_cnt - t0);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL pause_errs: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_reset_midframe;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            ps2_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        reset    = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if (ps2_key !== 11'h000) begin
            n_fail++;
            $display("FAIL midframe_reset_key: got %h expected %h", ps2_key, 11'h000);
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_err: got %b expected 0", frame_err);
        end
        repeat (40) @(negedge clk_sys);
        send_frame(8'h3C, 1'b0, 1'b0);
        n_tests++;
        if (ps2_key !== 11'h63C) begin
            n_fail++;
            $display("FAIL midframe_recover: got %h expected %h", ps2_key, 11'h63C);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        test_reset();
        test_make_break();
        test_extended();
        test_bad_parity();
        test_timeout();
        test_pause_noise();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Front-end PS/2 keyboard receiver that turns the raw PS/2 clock/data lines into the 11-bit `ps2_key` event word consumed by the Spectrum keyboard matrix stage. It synchronises and de-glitches both lines, deserialises 11-bit frames, checks parity and stop bits, and folds the E0/F0/E1 prefix bytes into one event per key press or release. It sits between the board PS/2 pins and the keyboard matrix block, in the `clk_sys` domain.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `clk_sys` samples needed before a filtered line changes (range 2..255).
- `TIMEOUT`, default 56000: number of `clk_sys` cycles without a filtered PS/2 clock falling edge that aborts a partial frame (about 2 ms at 28 MHz).

- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data, asynchronous, idle high.
- `ps2_key`  out  11  event word:
  - [10]: toggles once per event.
  - [9]: 1 = pressed, 0 = released.
  - [8]: extended (E0) flag.
  - [7:0]: scancode.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout abort.

## Operation
- **Synchroniser and filter**
  - Each input passes through a 2-flop synchroniser.
  - A per-line counter then updates the filtered level only after `FILTER_LEN` consecutive equal samples that differ from it.
  - Filtered levels reset to 1.
- **Edge detect:** a falling edge on the filtered clock produces a one-cycle `fall` strobe.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP), sampling filtered data on `fall`:
  - IDLE: data 0 -> DATA with bit count 0. Data 1 is ignored (false start).
  - DATA: shift in 8 bits LSB-first -> PARITY.
  - PARITY: record the bit -> STOP.
  - STOP: the frame is valid if the stop bit is 1 and data plus parity has odd weight. Otherwise pulse `frame_err`. Return to IDLE either way.
  - Watchdog: counts cycles since the last `fall` while not in IDLE. On reaching `TIMEOUT`, go to IDLE and pulse `frame_err`. The counter clears on every `fall` and in IDLE.
- **Byte decoder**, applied to each valid byte B:
  - E0: set `ext`.
  - F0: set `rel`.
  - E1: load `skip` = 7.
  - FA, AA, EE, FE, 00, FF: discard B and clear `ext` and `rel`.
  - While `skip` > 0: discard B and decrement `skip`. This swallows the Pause sequence and takes priority over all other rules.
  - Any other byte: `ps2_key` <= {~ps2_key[10], ~rel, ext, B}, then clear `ext` and `rel`.
- An invalid frame does not change `ext`, `rel` or `skip`.
- **Reset** clears:
  - FSM to IDLE
  - shift register
  - watchdog
  - `ext`, `rel`, `skip`
  - `ps2_key` to 0
  - `frame_err` to 0
  - filter counters, with both filtered levels set to 1

  A partial frame in flight is discarded.

## Timing
- Raw-to-filtered latency is 2 + `FILTER_LEN` cycles for a clean transition.
- `fall` asserts the cycle after the filtered clock goes 1->0.
- Byte completion happens in the cycle of the stop-bit `fall`. `ps2_key` and `frame_err` update on the next rising edge.
- `ps2_key` holds between events; bit 10 is the only event indicator. The downstream block detects events by comparing bit 10 with its previous value.
- Back-to-back events are supported at full PS/2 rate (each frame is ≥ 550 µs). No backpressure exists and none is needed.
- Glitches shorter than `FILTER_LEN` cycles on either line produce no `fall` and no level change.
- If `reset` and a `fall` arrive in the same cycle, reset wins.
- A timeout and a `fall` in the same cycle: the `fall` wins and the counter clears.

## Test plan
- **Make and break of A:** send frames 1C, then F0, then 1C (odd parity, stop 1) -> `ps2_key` = 0x21C with bit10 = 1, then 0x01C with bit10 = 0. Exactly two toggles, `frame_err` never asserts.
- **Extended Right Arrow:** send E0 74, then E0 F0 74 -> 0x374 with bit10 = 1, then 0x174 with bit10 = 0. The E0 and F0 bytes alone never toggle bit 10.
- **Bad parity:** send byte 5A with even parity -> one `frame_err` pulse, `ps2_key` unchanged. A following good 5A frame -> 0x25A with bit 10 toggled.
- **Timeout:** stop clocking after 4 data bits and wait `TIMEOUT` cycles -> `frame_err` pulses and the FSM is in IDLE. A full 16 frame afterwards decodes to 0x216.
- **Pause and noise:** send E1 14 77 E1 F0 14 F0 77, then 05, with 3-cycle glitches injected on `ps2_clk` -> exactly one event, 0x205 (F1). Separately, assert `reset` mid-frame -> `ps2_key` = 0x000 and the next frame decodes normally.
